// File: rtl/w0rm_core_alu_hs_if.sv
// W0RM core ALU handshake bundle.
// Carries the operand beat in and the tagged result out.
interface w0rm_core_alu_hs_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
);
  logic                  data_valid;
  logic                  data_ready;
  logic [3:0]            opcode;
  logic [3:0]            store_flags_mask;
  logic                  ext_bit_size;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]  tag_out;
  logic                  result_valid;
  logic                  result_ready;

  modport master (
    output data_valid,
    output opcode,
    output store_flags_mask,
    output ext_bit_size,
    output tag_in,
    output data_a,
    output data_b,
    output result_ready,
    input  data_ready,
    input  result,
    input  tag_out,
    input  result_valid
  );

  modport slave (
    input  data_valid,
    input  opcode,
    input  store_flags_mask,
    input  ext_bit_size,
    input  tag_in,
    input  data_a,
    input  data_b,
    input  result_ready,
    output data_ready,
    output result,
    output tag_out,
    output result_valid
  );
endinterface

// File: rtl/w0rm_core_alu_hs.sv
// W0RM core ALU, second generation: handshaked, tagged,
// with iterative multiply/divide and a persistent flag register.
module w0rm_core_alu_hs #(
  parameter int DATA_WIDTH       = 16,
  parameter int TAG_WIDTH        = 4,
  parameter bit ITERATIVE_MULDIV = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  w0rm_core_alu_hs_if.slave bus,
  output logic              flag_zero,
  output logic              flag_negative,
  output logic              flag_overflow,
  output logic              flag_carry,
  output logic              busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0] W_AMT = W'(W);
  localparam logic [W-1:0] MSB_ONLY = {1'b1, {(W-1){1'b0}}};

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h3;
  localparam logic [3:0] OP_NEG = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_REM = 4'h7;
  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_SEX = 4'hA;
  localparam logic [3:0] OP_ZEX = 4'hB;
  localparam logic [3:0] OP_LSR = 4'hC;
  localparam logic [3:0] OP_LSL = 4'hD;
  localparam logic [3:0] OP_ASR = 4'hE;
  localparam logic [3:0] OP_MOV = 4'hF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         v;
    logic         c;
  } calc_t;

  state_t               state;
  logic                 rdy_en;
  logic [3:0]           op_q;
  logic [3:0]           mask_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [W-1:0]         m_q;
  logic [W-1:0]         hi;
  logic [W-1:0]         lo;
  logic [CW-1:0]        cnt;
  logic [3:0]           flags;

  // Single-cycle datapath; MUL/DIV/REM here only when not iterated.
  function automatic calc_t calc(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ext
  );
    calc_t          r;
    logic [W:0]     wide;
    logic [W-1:0]   sh;
    logic [2*W-1:0] prod;
    logic           sh_zero;
    logic           sh_big;
    r       = '0;
    wide    = '0;
    sh      = '0;
    prod    = '0;
    sh_zero = (b == '0);
    sh_big  = (b >= W_AMT);
    unique case (op)
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_NOT: r.res = ~a;
      OP_NEG: begin
        r.res = '0 - a;
        r.c   = |a;
        r.v   = (a == MSB_ONLY);
      end
      OP_MUL: if (!ITERATIVE_MULDIV) begin
        prod  = (2*W)'(a) * (2*W)'(b);
        r.res = prod[W-1:0];
        r.v   = |prod[2*W-1:W];
      end
      OP_DIV: begin
        if (sh_zero) begin
          r.res = '1;
          r.v   = 1'b1;
        end else if (!ITERATIVE_MULDIV) begin
          r.res = a / b;
        end
      end
      OP_REM: begin
        if (sh_zero) begin
          r.res = a;
          r.v   = 1'b1;
        end else if (!ITERATIVE_MULDIV) begin
          r.res = a % b;
        end
      end
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r.res = wide[W-1:0];
        r.c   = wide[W];
        r.v   = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        r.res = wide[W-1:0];
        r.c   = wide[W];
        r.v   = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
      end
      OP_SEX: r.res = ext ? W'($signed(a[15:0])) : W'($signed(a[7:0]));
      OP_ZEX: r.res = ext ? W'(a[15:0]) : W'(a[7:0]);
      OP_LSR: begin
        if (sh_zero) r.res = a;
        else if (!sh_big) begin
          sh    = a >> (b - 1'b1);
          r.c   = sh[0];
          r.res = sh >> 1;
        end
      end
      OP_LSL: begin
        if (sh_zero) r.res = a;
        else if (!sh_big) begin
          sh    = a << (b - 1'b1);
          r.c   = sh[W-1];
          r.res = sh << 1;
        end
      end
      OP_ASR: begin
        if (sh_zero) r.res = a;
        else if (sh_big) begin
          r.res = {W{a[W-1]}};
          r.c   = a[W-1];
        end else begin
          sh    = $signed(a) >>> (b - 1'b1);
          r.c   = sh[0];
          r.res = $signed(sh) >>> 1;
        end
      end
      OP_MOV: r.res = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                 accept;
  logic                 go_iter;
  logic                 commit;
  logic [W:0]           mul_sum;
  logic [W:0]           div_rs;
  logic [W:0]           div_df;
  logic                 div_ge;
  logic [W-1:0]         nxt_hi;
  logic [W-1:0]         nxt_lo;
  calc_t                alu;
  logic [W-1:0]         fin_res;
  logic                 fin_v;
  logic                 fin_c;
  logic [3:0]           fin_mask;
  logic [TAG_WIDTH-1:0] fin_tag;
  logic [3:0]           new_flags;
  logic [3:0]           flags_nxt;

  assign bus.data_ready = rdy_en &
    ((state == IDLE) | ((state == DONE) & bus.result_ready));
  assign accept  = bus.data_valid & bus.data_ready;
  assign go_iter = ITERATIVE_MULDIV &&
    ((bus.opcode == OP_MUL) ||
     (((bus.opcode == OP_DIV) || (bus.opcode == OP_REM)) &&
      (bus.data_b != '0)));

  // hi:lo is the product (MUL) or remainder:quotient (DIV/REM).
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
    div_rs  = {hi, lo[W-1]};
    div_ge  = (div_rs >= {1'b0, m_q});
    div_df  = div_rs - {1'b0, m_q};
    if (op_q == OP_MUL) begin
      nxt_hi = mul_sum[W:1];
      nxt_lo = {mul_sum[0], lo[W-1:1]};
    end else begin
      nxt_hi = div_ge ? div_df[W-1:0] : div_rs[W-1:0];
      nxt_lo = {lo[W-2:0], div_ge};
    end
  end

  always_comb begin
    alu      = calc(bus.opcode, bus.data_a, bus.data_b,
                    bus.ext_bit_size);
    fin_res  = alu.res;
    fin_v    = alu.v;
    fin_c    = alu.c;
    fin_mask = bus.store_flags_mask;
    fin_tag  = bus.tag_in;
    if (state == BUSY) begin
      fin_res  = (op_q == OP_REM) ? nxt_hi : nxt_lo;
      fin_v    = (op_q == OP_MUL) & (|nxt_hi);
      fin_c    = 1'b0;
      fin_mask = mask_q;
      fin_tag  = tag_q;
    end
    new_flags = {fin_c, fin_v, fin_res[W-1], ~|fin_res};
    flags_nxt = (flags & ~fin_mask) | (new_flags & fin_mask);
    commit    = (accept & ~go_iter) |
                ((state == BUSY) & (cnt == LAST));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rdy_en      <= 1'b0;
      op_q        <= '0;
      mask_q      <= '0;
      tag_q       <= '0;
      m_q         <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      flags       <= '0;
      bus.result  <= '0;
      bus.tag_out <= '0;
    end else begin
      rdy_en <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q   <= bus.opcode;
            mask_q <= bus.store_flags_mask;
            tag_q  <= bus.tag_in;
            cnt    <= '0;
            hi     <= '0;
            if (bus.opcode == OP_MUL) begin
              m_q <= bus.data_a;
              lo  <= bus.data_b;
            end else begin
              m_q <= bus.data_b;
              lo  <= bus.data_a;
            end
            state <= go_iter ? BUSY : DONE;
          end else if (state == DONE && bus.result_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        bus.result  <= fin_res;
        bus.tag_out <= fin_tag;
        flags       <= flags_nxt;
      end
    end
  end

  assign bus.result_valid = (state == DONE);
  assign busy             = (state == BUSY);
  assign flag_zero        = flags[0];
  assign flag_negative    = flags[1];
  assign flag_overflow    = flags[2];
  assign flag_carry       = flags[3];
endmodule
